i2c_target: RTL and testbench

- I2C target (slave) engine, 7-bit addressing: the responder end of the bus driven by the team's I2C controller IP.
- Sits behind the same Caravel GPIO pad pair as the controller: scl_i/sda_i from io_in, SDA driven open-drain via sda_o/sda_oen_o into io_out/io_oeb (io_oeb = ~sda_oen_o).
- Byte-level handshake to a local register file or FIFO. No clock stretching: SCL is input-only.

---
 rtl/i2c_target_pkg.sv | 22 ++
 rtl/i2c_target_if.sv | 26 ++
 rtl/i2c_in_filter.sv | 47 ++++
 rtl/i2c_target.sv | 172 +++++++++++++++++
 tb/tb_i2c_target.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target engine and its input filters.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK,
    IGNORE
  } state_t;

  localparam int BITS_PER_BYTE = 8;

  // Width of a counter holding 0..len-1, never narrower than one bit.
  function automatic int filt_cnt_w(input int len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Pad-side and byte-side signals of the I2C target; slave = the target, master = its environment.
interface i2c_target_if;

  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       sda_oen_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_full_i;
  logic       tx_req_o;
  logic [7:0] tx_data_i;
  logic       busy_o;
  logic       stop_o;

  modport slave (
    input  scl_i, sda_i, rx_full_i, tx_data_i,
    output sda_o, sda_oen_o, rx_data_o, rx_valid_o, tx_req_o, busy_o, stop_o
  );

  modport master (
    output scl_i, sda_i, rx_full_i, tx_data_i,
    input  sda_o, sda_oen_o, rx_data_o, rx_valid_o, tx_req_o, busy_o, stop_o
  );

endinterface

// File: rtl/i2c_in_filter.sv
// 2-flop synchronizer plus FILTER_LEN-cycle stability filter with registered edge pulses.
// Input-to-level/edge latency is 2+FILTER_LEN cycles; no backpressure.
module i2c_in_filter
  import i2c_target_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = filt_cnt_w(FILTER_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      // Any return to the accepted level restarts the stability count.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync[1];
        cnt   <= '0;
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// 7-bit-address I2C target: bytes in/out through rx/tx handshakes, open-drain SDA, no clock stretching.
// Bus events act 2+FILTER_LEN cycles after the pads; a full sink is answered with NACK.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         FILTER_LEN  = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  i2c_target_if.slave  bus
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .raw   (bus.scl_i),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .raw   (bus.sda_i),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_cond, stop_cond, last_bit;
  assign start_cond = sda_fall & scl;
  assign stop_cond  = sda_rise & scl;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] sr;
  logic       rw;
  logic       nack;
  logic       oen;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  logic       stop_pls;

  assign last_bit = (cnt == 4'(BITS_PER_BYTE));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      rw       <= 1'b0;
      nack     <= 1'b0;
      oen      <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      stop_pls <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      stop_pls <= 1'b0;
      if (stop_cond) begin
        state    <= IDLE;
        oen      <= 1'b0;
        busy     <= 1'b0;
        stop_pls <= 1'b1;
      end else if (start_cond) begin
        state <= ADDR;
        cnt   <= '0;
        oen   <= 1'b0;
      end else if (tx_req) begin
        // The sink presents the read byte while tx_req is high; drive its MSB at once.
        sr  <= bus.tx_data_i;
        oen <= ~bus.tx_data_i[7];
      end else if (scl_rise) begin
        case (state)
          ADDR: begin
            sr  <= {sr[6:0], sda};
            cnt <= cnt + 4'd1;
          end
          WR: begin
            sr  <= {sr[6:0], sda};
            cnt <= cnt + 4'd1;
            if (cnt == 4'(BITS_PER_BYTE - 1)) begin
              nack <= bus.rx_full_i;
              if (!bus.rx_full_i) begin
                rx_data  <= {sr[6:0], sda};
                rx_valid <= 1'b1;
              end
            end
          end
          RD:      cnt  <= cnt + 4'd1;
          RD_ACK:  nack <= sda;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR: begin
            if (last_bit) begin
              if (sr[7:1] == TARGET_ADDR) begin
                oen   <= 1'b1;
                busy  <= 1'b1;
                rw    <= sr[0];
                state <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            cnt <= '0;
            if (rw) begin
              tx_req <= 1'b1;
              state  <= RD;
            end else begin
              oen   <= 1'b0;
              state <= WR;
            end
          end
          WR: begin
            if (last_bit) begin
              oen   <= ~nack;
              state <= WR_ACK;
            end
          end
          WR_ACK: begin
            oen   <= 1'b0;
            cnt   <= '0;
            state <= WR;
          end
          RD: begin
            if (last_bit) begin
              oen   <= 1'b0;
              state <= RD_ACK;
            end else begin
              sr  <= {sr[6:0], 1'b0};
              oen <= ~sr[6];
            end
          end
          RD_ACK: begin
            cnt <= '0;
            if (!nack) begin
              tx_req <= 1'b1;
              state  <= RD;
            end else begin
              state <= IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_o      = 1'b0;
  assign bus.sda_oen_o  = oen;
  assign bus.rx_data_o  = rx_data;
  assign bus.rx_valid_o = rx_valid;
  assign bus.tx_req_o   = tx_req;
  assign bus.busy_o     = busy;
  assign bus.stop_o     = stop_pls;

endmodule

// File: tb/tb_i2c_target.sv
// Randomized bus-level bench for i2c_target: a bit-banged controller plus a transaction-level expectation model.
module tb_i2c_target;

  localparam logic [6:0] TADDR = 7'h50;
  localparam int         Q     = 8;   // clk cycles per SCL quarter period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sda_ctl = 1'b1;

  i2c_target_if bus ();

  i2c_target #(.TARGET_ADDR(TADDR), .FILTER_LEN(3)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND of controller and target.
  assign bus.sda_i = sda_ctl & ~bus.sda_oen_o;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: only accumulates, tasks compare deltas.
  logic [7:0] rx_got[$];
  int tx_cnt = 0;
  int stop_cnt = 0;
  int oen_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid_o) rx_got.push_back(bus.rx_data_o);
      if (bus.tx_req_o)   tx_cnt++;
      if (bus.stop_o)     stop_cnt++;
      if (bus.sda_oen_o)  oen_cnt++;
    end
  end

  task automatic q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    sda_ctl = 1'b1; q(Q);
    bus.scl_i = 1'b1; q(Q);
    sda_ctl = 1'b0; q(Q);
    bus.scl_i = 1'b0; q(Q);
  endtask

  task automatic stop_c();
    sda_ctl = 1'b0; q(Q);
    bus.scl_i = 1'b1; q(Q);
    sda_ctl = 1'b1; q(Q);
  endtask

  task automatic wbit(input bit b, input bit glitch, output bit r);
    sda_ctl = b; q(Q);
    bus.scl_i = 1'b1;
    if (glitch) begin
      q(Q / 2);
      bus.scl_i = 1'b0; q(1);
      bus.scl_i = 1'b1; q(Q / 2);
    end else begin
      q(Q);
    end
    r = bus.sda_i; q(Q);
    bus.scl_i = 1'b0; q(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, input int gl, output bit ack);
    bit r;
    for (int i = 0; i < 8; i++) wbit(b[7-i], gl == i, r);
    wbit(1'b1, 1'b0, r);
    ack = ~r;
  endtask

  task automatic rbyte(input bit last, input logic [7:0] next, output logic [7:0] d);
    bit r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      wbit(1'b1, 1'b0, r);
      d = {d[6:0], r};
      if (i == 0) bus.tx_data_i = next;
    end
    wbit(last, 1'b0, r);
  endtask

  logic [7:0] dat[4];

  // One framed transaction; expectations come from the protocol rules only.
  task automatic txn(input logic [6:0] a, input bit rw, input int n, input logic [3:0] full, input int gl);
    bit         ack, match, exp_ack;
    logic [7:0] got;
    logic [7:0] exp_q[$];
    int rx0, tx0, st0, oe0;
    match = (a == TADDR);
    rx0 = rx_got.size(); tx0 = tx_cnt; st0 = stop_cnt; oe0 = oen_cnt;
    bus.tx_data_i = dat[0];
    start_c();
    wbyte({a, rw}, -1, ack);
    chk("addr_ack", ack, match);
    chk("busy_addr", bus.busy_o, match);
    if (match && rw) begin
      for (int i = 0; i < n; i++) begin
        rbyte(i == n - 1, (i + 1 < n) ? dat[i+1] : 8'h00, got);
        chk("rd_data", got, dat[i]);
      end
    end else if (!rw) begin
      for (int i = 0; i < n; i++) begin
        bus.rx_full_i = full[i];
        wbyte(dat[i], (i == 0) ? gl : -1, ack);
        bus.rx_full_i = 1'b0;
        exp_ack = match && !full[i];
        chk("wr_ack", ack, exp_ack);
        if (exp_ack) exp_q.push_back(dat[i]);
      end
    end
    stop_c();
    q(Q);
    chk("rx_count", rx_got.size() - rx0, exp_q.size());
    foreach (exp_q[k]) if (rx0 + k < rx_got.size()) chk("rx_data", rx_got[rx0+k], exp_q[k]);
    chk("tx_req_count", tx_cnt - tx0, (match && rw) ? n : 0);
    chk("stop_count", stop_cnt - st0, 1);
    chk("busy_end", bus.busy_o, 0);
    if (!match) chk("oen_quiet", oen_cnt - oe0, 0);
  endtask

  initial begin
    bit         ack;
    logic [7:0] got;
    int         rx0, tx0;
    logic [6:0] a;

    bus.scl_i = 1'b1;
    bus.rx_full_i = 1'b0;
    bus.tx_data_i = 8'h00;
    q(4);
    chk("rst_oen", bus.sda_oen_o, 0);
    chk("rst_sda_o", bus.sda_o, 0);
    chk("rst_rx_data", bus.rx_data_o, 0);
    chk("rst_rx_valid", bus.rx_valid_o, 0);
    chk("rst_tx_req", bus.tx_req_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_stop", bus.stop_o, 0);
    rst_n = 1'b1;
    q(10);

    // Plain write of two bytes.
    dat[0] = 8'h3C; dat[1] = 8'hC3;
    txn(TADDR, 1'b0, 2, 4'b0000, -1);

    // Foreign address (0xA2 on the wire).
    dat[0] = 8'h11;
    txn(7'h51, 1'b0, 1, 4'b0000, -1);

    // Two-byte read, ACK then NACK.
    dat[0] = 8'h5A; dat[1] = 8'h81;
    txn(TADDR, 1'b1, 2, 4'b0000, -1);

    // Sink full on the second byte.
    dat[0] = 8'h01; dat[1] = 8'h02;
    txn(TADDR, 1'b0, 2, 4'b0010, -1);

    // Repeated START four bits into a data byte, then a one-byte read.
    rx0 = rx_got.size(); tx0 = tx_cnt;
    start_c();
    wbyte({TADDR, 1'b0}, -1, ack);
    chk("sr_addr_ack", ack, 1);
    for (int i = 0; i < 4; i++) begin
      bit r;
      wbit(1'($urandom), 1'b0, r);
    end
    dat[0] = 8'($urandom);
    bus.tx_data_i = dat[0];
    start_c();
    wbyte({TADDR, 1'b1}, -1, ack);
    chk("sr_rd_ack", ack, 1);
    rbyte(1'b1, 8'h00, got);
    chk("sr_rd_data", got, dat[0]);
    stop_c();
    q(Q);
    chk("sr_rx_count", rx_got.size() - rx0, 0);
    chk("sr_tx_req", tx_cnt - tx0, 1);

    // One-cycle SCL low glitch in bit 3 of a data byte must not count as a clock.
    dat[0] = 8'($urandom);
    txn(TADDR, 1'b0, 1, 4'b0000, 3);

    // Reset while the target is pulling SDA low for a read bit.
    dat[0] = 8'($urandom) & 8'h7F;
    bus.tx_data_i = dat[0];
    start_c();
    wbyte({TADDR, 1'b1}, -1, ack);
    chk("rr_addr_ack", ack, 1);
    sda_ctl = 1'b1; q(Q);
    bus.scl_i = 1'b1; q(Q);
    chk("rr_driving", bus.sda_oen_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_async_oen", bus.sda_oen_o, 0);
    chk("rr_busy", bus.busy_o, 0);
    q(2);
    rst_n = 1'b1;
    q(Q);
    bus.scl_i = 1'b0; q(Q);
    rx0 = rx_got.size();
    wbyte({TADDR, 1'b0}, -1, ack);
    chk("rr_idle_nack", ack, 0);
    chk("rr_idle_busy", bus.busy_o, 0);
    stop_c();
    q(Q);
    chk("rr_idle_rx", rx_got.size() - rx0, 0);

    // Random transactions.
    for (int k = 0; k < 10; k++) begin
      a = $urandom_range(0, 1) ? TADDR : 7'($urandom);
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      txn(a, 1'($urandom), $urandom_range(1, 3), 4'($urandom) & 4'($urandom), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
